// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared encodings for the JK command sequencer: operations, FSM states and the
// op-to-J/K decode used ahead of the output registers.
package jk_cmd_sequencer_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_HOLD   = 2'b00,
      OP_CLEAR  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic j;
      logic k;
   } jk_t;

   function automatic jk_t op_to_jk(input op_e op);
      jk_t r_jk;
      r_jk = '0;
      case (op)
         OP_CLEAR:  r_jk = '{j: 1'b0, k: 1'b1};
         OP_SET:    r_jk = '{j: 1'b1, k: 1'b0};
         OP_TOGGLE: r_jk = '{j: 1'b1, k: 1'b1};
         default:   r_jk = '{j: 1'b0, k: 1'b0};
      endcase
      return r_jk;
   endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with power-of-two depth; pointers wrap naturally and an
// extra occupancy bit distinguishes full from empty.
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // A full FIFO refuses pushes even when a pop happens in the same cycle.
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign full   = (r_count == CNT_FULL);
   assign empty  = (r_count == '0);
   assign dout   = r_mem[r_rptr];

   // NOTE: storage has no reset; only the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues JK commands and replays each one as registered enabled/J/K for its repeat
// count, chaining queued commands back-to-back and pulsing done after each.
module jk_cmd_sequencer
   import jk_cmd_sequencer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             cmd_ready,
   output logic             enabled,
   output logic             J,
   output logic             K,
   output logic             busy,
   output logic             done
);

   localparam int DW = OP_W + CNT_W;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DW-1:0]    w_fifo_din;
   logic [DW-1:0]    w_fifo_dout;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_last;
   op_e              w_head_op;
   logic [CNT_W-1:0] w_head_count;
   jk_t              w_head_jk;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] w_remaining_nxt;
   logic             r_enabled, r_j, r_k, r_done;
   logic             w_enabled_nxt, w_j_nxt, w_k_nxt, w_done_nxt;

   assign cmd_ready  = ~w_full;
   assign w_push     = cmd_valid & ~w_full;
   assign w_fifo_din = {cmd_op, cmd_count};

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_fifo_din),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   assign w_head_op    = op_e'(w_fifo_dout[DW-1 -: OP_W]);
   assign w_head_count = w_fifo_dout[CNT_W-1:0];
   assign w_head_jk    = op_to_jk(w_head_op);
   assign w_last       = (r_state == ST_RUN) && (r_remaining == CNT_ONE);
   // The head is taken from IDLE, or in the final cycle of a command so the next one follows with no gap.
   assign w_pop        = ~w_empty && ((r_state == ST_IDLE) || w_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_enabled   <= 1'b0;
         r_j         <= 1'b0;
         r_k         <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_enabled   <= w_enabled_nxt;
         r_j         <= w_j_nxt;
         r_k         <= w_k_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      case (r_state)
         ST_IDLE: begin
            if (w_pop) begin
               w_state_nxt     = ST_RUN;
               w_remaining_nxt = (w_head_count == '0) ? CNT_ONE : w_head_count;
            end
         end
         ST_RUN: begin
            if (w_pop) begin
               w_remaining_nxt = (w_head_count == '0) ? CNT_ONE : w_head_count;
            end else if (w_last) begin
               w_state_nxt     = ST_IDLE;
               w_remaining_nxt = '0;
            end else begin
               w_remaining_nxt = r_remaining - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_enabled_nxt = r_enabled;
      w_j_nxt       = r_j;
      w_k_nxt       = r_k;
      w_done_nxt    = w_last;
      if (w_pop) begin
         w_enabled_nxt = 1'b1;
         w_j_nxt       = w_head_jk.j;
         w_k_nxt       = w_head_jk.k;
      end else if (w_last) begin
         w_enabled_nxt = 1'b0;
         w_j_nxt       = 1'b0;
         w_k_nxt       = 1'b0;
      end
   end

   assign enabled = r_enabled;
   assign J       = r_j;
   assign K       = r_k;
   assign busy    = (r_state == ST_RUN);
   assign done    = r_done;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: a queue-based command model is compared on
// every falling edge, and hand-computed expectations pin the key scenarios.
module tb_jk_cmd_sequencer;
   import jk_cmd_sequencer_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid = 1'b0;
   logic [1:0]       cmd_op = 2'b00;
   logic [CNT_W-1:0] cmd_count = '0;
   logic             cmd_ready, enabled, J, K, busy, done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   jk_cmd_sequencer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_count (cmd_count),
      .cmd_ready (cmd_ready),
      .enabled   (enabled),
      .J         (J),
      .K         (K),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: accepted commands wait in a queue; the active one has a count of cycles left.
   typedef struct {
      int op;
      int cnt;
   } mcmd_t;

   mcmd_t      mq[$];
   int         m_left = 0;
   logic       m_en = 1'b0, m_j = 1'b0, m_k = 1'b0, m_done = 1'b0;
   logic [1:0] jk_tab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_left = 0;
         m_en   = 1'b0;
         m_j    = 1'b0;
         m_k    = 1'b0;
         m_done = 1'b0;
      end else begin
         bit    acc;
         mcmd_t c;
         mcmd_t n;
         acc    = cmd_valid && (mq.size() < DEPTH);
         m_done = (m_left == 1);
         if (m_left > 1) begin
            m_left--;
         end else if (mq.size() > 0) begin
            c      = mq.pop_front();
            m_left = (c.cnt == 0) ? 1 : c.cnt;
            m_en   = 1'b1;
            {m_j, m_k} = jk_tab[c.op];
         end else begin
            m_left = 0;
            m_en   = 1'b0;
            m_j    = 1'b0;
            m_k    = 1'b0;
         end
         if (acc) begin
            n.op  = int'(cmd_op);
            n.cnt = int'(cmd_count);
            mq.push_back(n);
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_enabled", enabled, m_en);
      check("cmp_J", J, m_j);
      check("cmp_K", K, m_k);
      check("cmp_busy", busy, (m_left > 0));
      check("cmp_done", done, m_done);
      check("cmp_ready", cmd_ready, (mq.size() < DEPTH));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] op, input int cnt);
      bit acc;
      bit ok;
      ok        = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_count = cnt[CNT_W-1:0];
      for (int i = 0; i < 60; i++) begin
         acc = cmd_ready;
         tick();
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      cmd_valid = 1'b0;
      check("push_accepted", ok, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!busy && !done && mq.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("idle_reached", ok, 1);
   endtask

   initial begin
      reset = 1'b0;
      #2;
      check("rst_ready", cmd_ready, 1);
      check("rst_enabled", enabled, 0);
      check("rst_J", J, 0);
      check("rst_K", K, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Single SET, count 1: visible after the edge following acceptance.
      push(OP_SET, 1);
      check("set_latency_en", enabled, 0);
      tick();
      check("set_en", enabled, 1);
      check("set_J", J, 1);
      check("set_K", K, 0);
      check("set_busy", busy, 1);
      tick();
      check("set_end_en", enabled, 0);
      check("set_done", done, 1);
      tick();
      check("set_done_clear", done, 0);

      // TOGGLE x3 followed immediately by CLEAR x2.
      push(OP_TOGGLE, 3);
      push(OP_CLEAR, 2);
      check("b2b_tog1_en", enabled, 1);
      check("b2b_tog1_JK", {J, K}, 2'b11);
      tick();
      tick();
      check("b2b_tog3_JK", {J, K}, 2'b11);
      check("b2b_tog3_done", done, 0);
      tick();
      check("b2b_clr1_en", enabled, 1);
      check("b2b_clr1_JK", {J, K}, 2'b01);
      check("b2b_done1", done, 1);
      tick();
      check("b2b_clr2_JK", {J, K}, 2'b01);
      check("b2b_clr2_done", done, 0);
      tick();
      check("b2b_end_en", enabled, 0);
      check("b2b_done2", done, 1);
      tick();

      // HOLD with count 0 runs for exactly one cycle.
      push(OP_HOLD, 0);
      tick();
      check("hold0_en", enabled, 1);
      check("hold0_JK", {J, K}, 2'b00);
      tick();
      check("hold0_end_en", enabled, 0);
      check("hold0_done", done, 1);
      tick();

      // Fill the FIFO behind a long TOGGLE; the last two pushes stall until space frees.
      push(OP_TOGGLE, 15);
      tick();
      push(OP_SET, 1);
      push(OP_CLEAR, 2);
      push(OP_HOLD, 1);
      push(OP_SET, 3);
      check("full_ready", cmd_ready, 0);
      check("full_busy", busy, 1);
      push(OP_TOGGLE, 2);
      push(OP_CLEAR, 1);
      wait_idle();

      // Reset in the 2nd cycle of TOGGLE x5 with two commands queued.
      push(OP_TOGGLE, 5);
      push(OP_SET, 2);
      push(OP_CLEAR, 3);
      check("midrst_pre_JK", {J, K}, 2'b11);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_en", enabled, 0);
      check("midrst_JK", {J, K}, 2'b00);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_ready", cmd_ready, 1);
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("postrst_en", enabled, 0);
         check("postrst_done", done, 0);
      end

      // Ten pushes in a row exercise pointer wrap-around.
      for (int i = 0; i < 10; i++) begin
         push(2'(i % 4), i % 3);
      end
      wait_idle();
      check("final_ready", cmd_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
